mod_pow4_seq: RTL and testbench

Sequencer that computes (iData × 4^k) mod iMod by cycling one operand k times through a single registered modular quadrupler (`mod_quadrupler_reg`). It sits in front of the modular-arithmetic datapath. It accepts one job at a time over a valid/ready handshake, latches the operands, schedules the quadrupler, and holds the result until the consumer takes it.

---
 rtl/mod_seq_pkg.sv | 33 +++
 rtl/mod_quadrupler_reg.sv | 55 +++++
 rtl/mod_pow4_seq.sv | 136 +++++++++++++
 tb/tb_mod_pow4_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_seq_pkg
// Purpose  : Shared types and reference arithmetic for the modular sequencers.
// Revision : 1.0 - initial release
// ============================================================================
package mod_seq_pkg;

    localparam int c_BITWIDTH = 32;
    localparam int c_INTER_W  = c_BITWIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Reference 4*x mod m; a modulus of 0 or 1 yields 0.
    function automatic logic [c_BITWIDTH-1:0] modQuad(
        input logic [c_BITWIDTH-1:0] x,
        input logic [c_BITWIDTH-1:0] m
    );
        logic [c_INTER_W-1:0] prod;
        logic [c_INTER_W-1:0] res;
        prod = {x, 2'b00};
        if (m[c_BITWIDTH-1:1] == '0) res = '0;
        else                         res = prod % {2'b00, m};
        return res[c_BITWIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_quadrupler_reg.sv
`default_nettype none
// ============================================================================
// Module   : mod_quadrupler_reg
// Purpose  : Registered 4*x mod m for x < m, one-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module mod_quadrupler_reg #(
    parameter int BITWIDTH = 32
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iMod,
    output logic [BITWIDTH-1:0] oData
);

    localparam int INTW = BITWIDTH + 2;

    logic [INTW-1:0]     w_prod;
    logic [INTW-1:0]     w_mod1;
    logic [INTW-1:0]     w_mod2;
    logic [INTW-1:0]     w_sub1;
    logic [INTW-1:0]     w_sub2;
    logic                w_degenerate;
    logic [BITWIDTH-1:0] w_next;
    logic [BITWIDTH-1:0] r_data;

    // With x < m the product is below 4m, so two conditional subtractions
    // (2m then m) fully reduce it without a divider.
    always_comb begin
        w_prod       = {iData, 2'b00};
        w_mod1       = {2'b00, iMod};
        w_mod2       = {1'b0, iMod, 1'b0};
        w_sub1       = (w_prod >= w_mod2) ? (w_prod - w_mod2) : w_prod;
        w_sub2       = (w_sub1 >= w_mod1) ? (w_sub1 - w_mod1) : w_sub1;
        w_degenerate = (iMod[BITWIDTH-1:1] == '0);
        w_next       = w_degenerate ? '0 : BITWIDTH'(w_sub2);
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_data <= '0;
        end else if (iClr) begin
            r_data <= '0;
        end else if (iEn) begin
            r_data <= w_next;
        end
    end

    assign oData = r_data;

endmodule
`default_nettype wire

// File: rtl/mod_pow4_seq.sv
`default_nettype none
// ============================================================================
// Module   : mod_pow4_seq
// Purpose  : Computes (x * 4^k) mod m by cycling a registered quadrupler.
//            Optional pre-reduction of x: MOD_POW4_SEQ_PRE_REDUCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mod_pow4_seq
    import mod_seq_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int EXPW     = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iValid,
    output logic                oReady,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iMod,
    input  logic [EXPW-1:0]     iExp,
    output logic                oValid,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oData
);

    state_t              r_state;
    state_t              w_nextState;
    logic [BITWIDTH-1:0] r_acc;
    logic [BITWIDTH-1:0] r_mod;
    logic [EXPW-1:0]     r_k;
    logic [EXPW-1:0]     r_cnt;
    logic                r_oValid;
    logic [EXPW:0]       w_cntInc;
    logic                w_lastStep;
    logic [BITWIDTH-1:0] w_quadIn;
    logic [BITWIDTH-1:0] w_quadOut;
`ifdef MOD_POW4_SEQ_PRE_REDUCE_EN
    logic [BITWIDTH-1:0] w_reduced;
    assign w_reduced = (r_mod[BITWIDTH-1:1] == '0) ? '0 : (r_acc % r_mod);
`endif

    assign w_cntInc   = {1'b0, r_cnt} + {{EXPW{1'b0}}, 1'b1};
    assign w_lastStep = (w_cntInc == {1'b0, r_k});
    // First step seeds the quadrupler from the accumulator; later steps chain
    // its own registered output so one step completes per cycle.
    assign w_quadIn   = (r_cnt == '0) ? r_acc : w_quadOut;

    mod_quadrupler_reg #(
        .BITWIDTH (BITWIDTH)
    ) u_quad (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (iEn),
        .iClr  (iClr),
        .iData (w_quadIn),
        .iMod  (r_mod),
        .oData (w_quadOut)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (iClr) begin
            w_nextState = ST_IDLE;
        end else if (iEn) begin
            case (r_state)
                ST_IDLE: begin
                    if (iValid) begin
`ifdef MOD_POW4_SEQ_PRE_REDUCE_EN
                        w_nextState = ST_REDUCE;
`else
                        w_nextState = (iExp == '0) ? ST_DONE : ST_RUN;
`endif
                    end
                end
`ifdef MOD_POW4_SEQ_PRE_REDUCE_EN
                ST_REDUCE: w_nextState = (r_k == '0) ? ST_DONE : ST_RUN;
`endif
                ST_RUN:  if (w_lastStep) w_nextState = ST_DONE;
                ST_DONE: if (r_oValid && iReady) w_nextState = ST_IDLE;
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_acc    <= '0;
            r_mod    <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_oValid <= 1'b0;
        end else if (iClr) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_oValid <= 1'b0;
        end else if (iEn) begin
            case (r_state)
                ST_IDLE: begin
                    if (iValid) begin
                        r_acc <= iData;
                        r_mod <= iMod;
                        r_k   <= iExp;
                        r_cnt <= '0;
                    end
                end
`ifdef MOD_POW4_SEQ_PRE_REDUCE_EN
                ST_REDUCE: r_acc <= w_reduced;
`endif
                ST_RUN: r_cnt <= w_cntInc[EXPW-1:0];
                ST_DONE: begin
                    // First DONE cycle captures the final quadrupler value.
                    if (!r_oValid) begin
                        r_oValid <= 1'b1;
                        if (r_k != '0) r_acc <= w_quadOut;
                    end else if (iReady) begin
                        r_oValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oReady = (r_state == ST_IDLE);
    assign oValid = r_oValid;
    assign oData  = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_mod_pow4_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_pow4_seq
// Purpose  : Self-checking bench for mod_pow4_seq against a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_pow4_seq;
    import mod_seq_pkg::*;

`ifdef MOD_POW4_SEQ_PRE_REDUCE_EN
    localparam int PRE = 1;
`else
    localparam int PRE = 0;
`endif

    logic        iClk, iRstN, iEn, iClr, iValid, iReady;
    logic [31:0] iData, iMod;
    logic [7:0]  iExp;
    logic        oReady, oValid;
    logic [31:0] oData;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 0;

    mod_pow4_seq #(.BITWIDTH(32), .EXPW(8)) dut (
        .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr),
        .iValid(iValid), .oReady(oReady), .iData(iData), .iMod(iMod),
        .iExp(iExp), .oValid(oValid), .iReady(iReady), .oData(oData)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] refPow4(input logic [31:0] x, input logic [31:0] m,
                                            input logic [7:0] k);
        longint unsigned r;
        longint unsigned mm;
        if (m <= 32'd1) return 32'd0;
        mm = {32'b0, m};
        r  = {32'b0, x} % mm;
        for (int i = 0; i < int'(k); i++) r = (r * 4) % mm;
        return r[31:0];
    endfunction

    // Behavioural model: one job in flight, fixed latency counted in enabled cycles.
    logic        mReady, mValid, mBusy;
    int          mRem;
    logic [31:0] mData;

    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            mReady <= 1'b1; mValid <= 1'b0; mBusy <= 1'b0; mRem <= 0; mData <= 32'd0;
        end else if (iClr) begin
            mReady <= 1'b1; mValid <= 1'b0; mBusy <= 1'b0; mRem <= 0;
        end else if (iEn) begin
            if (mReady) begin
                if (iValid) begin
                    mReady <= 1'b0;
                    mBusy  <= 1'b1;
                    mRem   <= int'(iExp) + 1 + PRE;
                    mData  <= refPow4(iData, iMod, iExp);
                end
            end else if (mBusy && !mValid) begin
                mRem <= mRem - 1;
                if (mRem == 1) mValid <= 1'b1;
            end else if (mValid && iReady) begin
                mValid <= 1'b0;
                mReady <= 1'b1;
                mBusy  <= 1'b0;
            end
        end
    end

    always @(negedge iClk) begin
        if (checkEn && iRstN) begin
            check("oReady", {31'b0, oReady}, {31'b0, mReady});
            check("oValid", {31'b0, oValid}, {31'b0, mValid});
            if (mValid) check("oData", oData, mData);
        end
    end

    // Runs one job; stallAt < 0 means no iEn stall.
    task automatic doJob(input logic [31:0] x, input logic [31:0] m, input logic [7:0] k,
                         input int holdOff, input int stallAt, input int stallLen,
                         output logic [31:0] res, output int lat);
        int guard;
        @(negedge iClk);
        guard = 0;
        while (!oReady && guard < 100) begin
            @(negedge iClk);
            guard++;
        end
        check("readyTimeout", {31'b0, oReady}, 32'd1);
        #1;
        iValid = 1'b1; iData = x; iMod = m; iExp = k;
        @(posedge iClk);
        #1;
        iValid = 1'b0; iData = $urandom; iMod = $urandom; iExp = 8'($urandom);
        lat = 0;
        while (!oValid && lat < 600) begin
            if (lat == stallAt) iEn = 1'b0;
            if (lat == stallAt + stallLen) iEn = 1'b1;
            @(posedge iClk);
            #1;
            lat++;
        end
        iEn = 1'b1;
        check("validTimeout", {31'b0, oValid}, 32'd1);
        res = oData;
        for (int i = 0; i < holdOff; i++) begin
            @(posedge iClk);
            #1;
            check("holdValid", {31'b0, oValid}, 32'd1);
            check("holdData", oData, res);
        end
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        iReady = 1'b0;
        check("dropValid", {31'b0, oValid}, 32'd0);
        check("readyBack", {31'b0, oReady}, 32'd1);
    endtask

    initial begin
        logic [31:0] res, x, m, r;
        int          lat;
        logic [7:0]  k;

        iClk = 0; iRstN = 0; iEn = 1; iClr = 0; iValid = 0; iReady = 0;
        iData = 0; iMod = 0; iExp = 0;
        #12;
        check("rstReady", {31'b0, oReady}, 32'd1);
        check("rstValid", {31'b0, oValid}, 32'd0);
        check("rstData",  oData, 32'd0);
        @(negedge iClk);
        iRstN = 1;
        checkEn = 1;

        doJob(32'd5, 32'd23, 8'd3, 0, -1, 0, res, lat);
        check("pow4_5_3", res, 32'd21);
        check("lat_k3", lat, 32'(4 + PRE));

        doJob(32'd7, 32'd23, 8'd0, 0, -1, 0, res, lat);
        check("pow4_7_0", res, 32'd7);
        check("lat_k0", lat, 32'(1 + PRE));
`ifdef MOD_POW4_SEQ_PRE_REDUCE_EN
        doJob(32'd30, 32'd23, 8'd0, 0, -1, 0, res, lat);
        check("reduce_30", res, 32'd7);
`endif

        doJob(32'd1, 32'd23, 8'd2, 5, -1, 0, res, lat);
        check("pow4_1_2", res, 32'd16);

        // Abort via iClr during the fourth RUN cycle.
        @(negedge iClk); #1;
        iValid = 1; iData = 32'd3; iMod = 32'd23; iExp = 8'd10;
        @(posedge iClk); #1;
        iValid = 0;
        repeat (3 + PRE) begin @(posedge iClk); #1; end
        iClr = 1;
        @(posedge iClk); #1;
        iClr = 0;
        check("clrReady", {31'b0, oReady}, 32'd1);
        check("clrValid", {31'b0, oValid}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            @(posedge iClk); #1;
            if (oValid) check("clrNoValid", {31'b0, oValid}, 32'd0);
        end
        doJob(32'd2, 32'd23, 8'd1, 0, -1, 0, res, lat);
        check("pow4_2_1", res, 32'd8);

        // Large modulus with a 3-cycle stall mid-RUN.
        doJob(32'd999999, 32'd1000003, 8'd5, 1, 2 + PRE, 3, res, lat);
        r = 32'd999999;
        for (int i = 0; i < 5; i++) r = modQuad(r, 32'd1000003);
        check("bigMod", res, r);
        check("lat_stall", lat, 32'(5 + 1 + 3 + PRE));

        // Asynchronous reset mid-RUN.
        @(negedge iClk); #1;
        iValid = 1; iData = 32'd3; iMod = 32'd23; iExp = 8'd10;
        @(posedge iClk); #1;
        iValid = 0;
        repeat (3) @(posedge iClk);
        #3;
        iRstN = 0;
        #1;
        check("arstValid", {31'b0, oValid}, 32'd0);
        check("arstData",  oData, 32'd0);
        check("arstReady", {31'b0, oReady}, 32'd1);
        @(negedge iClk); #1;
        iRstN = 1;

        for (int j = 0; j < 200; j++) begin
            case ($urandom % 4)
                0:       m = $urandom_range(50, 2);
                1:       m = $urandom | 32'h8000_0000;
                2:       m = 32'd1;
                default: m = $urandom | 32'd1;
            endcase
`ifdef MOD_POW4_SEQ_PRE_REDUCE_EN
            x = $urandom;
            if ($urandom % 16 == 0) m = 32'd0;
`else
            x = (m <= 32'd1) ? 32'd0 : ($urandom % m);
`endif
            k = 8'($urandom_range(12, 0));
            doJob(x, m, k, $urandom_range(3, 0),
                  ($urandom % 3 == 0) ? $urandom_range(int'(k), 0) : -1,
                  $urandom_range(2, 1), res, lat);
            check("rand", res, refPow4(x, m, k));
        end

        checkEn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
